// File: rtl/ddr3_pg_pkg.sv
// Shared definitions for the DDR3 page-transfer arbiter and transfer controller.
package ddr3_pg_pkg;

  localparam int unsigned DdrAddrW = 28;

  typedef enum logic {
    OPREAD  = 1'b0,
    OPWRITE = 1'b1
  } pg_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRelease = 2'd2
  } pg_state_e;

endpackage

// File: rtl/ddr3_pg_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant, with wrap.
module rr_pick
  import ddr3_pg_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last_grant,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  // Two ordered passes: indices above last_grant first, then the wrapped-around ones.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && (IdxW'(i) > last_grant)) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && (IdxW'(i) <= last_grant)) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_pg_arbiter.sv
// Round-robin arbiter sharing one DDR3 page-transfer controller among NREQ requesters.
module ddr3_pg_arbiter
  import ddr3_pg_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              req_optype,
  input  logic [DdrAddrW*NREQ-1:0]     req_addr,
  output logic [NREQ-1:0]              req_ack,
  output logic                         req_err,
  output logic [NREQ-1:0]              grant,
  output logic                         pg_req,
  output logic                         pg_optype,
  output logic [DdrAddrW-1:0]          pg_req_addr,
  input  logic                         pg_ack,
  output logic                         busy,
  output logic                         timeout_err,
  input  logic                         err_clr
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = ($clog2(TIMEOUT) > 12) ? $clog2(TIMEOUT) : 12;

  pg_state_e            state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      req_ack_q, req_ack_d;
  logic                 req_err_q, req_err_d;
  logic                 pg_req_q, pg_req_d;
  logic                 pg_optype_q, pg_optype_d;
  logic [DdrAddrW-1:0]  pg_addr_q, pg_addr_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      last_grant_q, last_grant_d;

  logic [NREQ-1:0]      pick_oh;
  logic                 pick_valid;
  logic [DdrAddrW-1:0]  sel_addr;
  logic                 sel_op;
  logic [IdxW-1:0]      grant_idx;
  logic                 cnt_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (pick_oh),
    .valid      (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_op    = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = req_addr[DdrAddrW*i +: DdrAddrW];
        sel_op   = req_optype[i];
      end
      if (grant_q[i]) grant_idx = IdxW'(i);
    end
  end

  assign cnt_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      req_ack_q     <= '0;
      req_err_q     <= 1'b0;
      pg_req_q      <= 1'b0;
      pg_optype_q   <= OPREAD;
      pg_addr_q     <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      last_grant_q  <= IdxW'(NREQ - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      req_ack_q     <= req_ack_d;
      req_err_q     <= req_err_d;
      pg_req_q      <= pg_req_d;
      pg_optype_q   <= pg_optype_d;
      pg_addr_q     <= pg_addr_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pick_valid) state_d = StIssue;
      StIssue:   if (pg_ack || cnt_hit) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    req_ack_d     = '0;
    req_err_d     = 1'b0;
    pg_req_d      = pg_req_q;
    pg_optype_d   = pg_optype_q;
    pg_addr_d     = pg_addr_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d     = pick_oh;
          pg_req_d    = 1'b1;
          pg_optype_d = sel_op;
          pg_addr_d   = sel_addr;
          cnt_d       = '0;
        end
      end
      StIssue: begin
        // pg_ack outranks a timeout landing on the same cycle.
        if (pg_ack || cnt_hit) begin
          pg_req_d     = 1'b0;
          req_ack_d    = grant_q;
          last_grant_d = grant_idx;
          if (!pg_ack) begin
            req_err_d     = 1'b1;
            timeout_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: grant_d = '0;
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign req_ack     = req_ack_q;
  assign req_err     = req_err_q;
  assign pg_req      = pg_req_q;
  assign pg_optype   = pg_optype_q;
  assign pg_req_addr = pg_addr_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ddr3_pg_arbiter.sv
// Directed bench: short-timeout instance for most scenarios, default-timeout one for long waits.
module tb_ddr3_pg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_optype;
  logic [55:0] req_addr;
  logic        pg_ack;
  logic        l_pg_ack;
  logic        err_clr;

  logic [1:0]  req_ack, grant;
  logic        req_err, pg_req, pg_optype, busy, timeout_err;
  logic [27:0] pg_req_addr;

  logic [1:0]  l_req_ack, l_grant;
  logic        l_req_err, l_pg_req, l_pg_optype, l_busy, l_timeout_err;
  logic [27:0] l_pg_req_addr;

  int n_checks;
  int n_pass;

  ddr3_pg_arbiter #(
    .NREQ    (2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_optype  (req_optype),
    .req_addr    (req_addr),
    .req_ack     (req_ack),
    .req_err     (req_err),
    .grant       (grant),
    .pg_req      (pg_req),
    .pg_optype   (pg_optype),
    .pg_req_addr (pg_req_addr),
    .pg_ack      (pg_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  ddr3_pg_arbiter #(
    .NREQ    (2),
    .TIMEOUT (4096)
  ) dut_long (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_optype  (req_optype),
    .req_addr    (req_addr),
    .req_ack     (l_req_ack),
    .req_err     (l_req_err),
    .grant       (l_grant),
    .pg_req      (l_pg_req),
    .pg_optype   (l_pg_optype),
    .pg_req_addr (l_pg_req_addr),
    .pg_ack      (l_pg_ack),
    .busy        (l_busy),
    .timeout_err (l_timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n      = 1'b0;
    req        = 2'b00;
    req_optype = 2'b00;
    req_addr   = '0;
    pg_ack     = 1'b0;
    l_pg_ack   = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pg_req, grant, req_ack, req_err, busy, timeout_err} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {pg_req, grant, req_ack, req_err, busy, timeout_err});
    else n_pass++;
    n_checks++;
    if (pg_optype !== 1'b0 || pg_req_addr !== 28'h0)
      $display("FAIL reset_data: got op=%b addr=%h want op=0 addr=0", pg_optype, pg_req_addr);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req        = 2'b01;
    req_optype = 2'b01;
    req_addr   = '0;
    @(negedge clk);
    n_checks++;
    if (pg_req !== 1'b1 || grant !== 2'b01 || busy !== 1'b1)
      $display("FAIL single_issue: got pg_req=%b grant=%b busy=%b want 1 01 1",
               pg_req, grant, busy);
    else n_pass++;
    n_checks++;
    if (pg_optype !== 1'b1 || pg_req_addr !== 28'h0)
      $display("FAIL single_data: got op=%b addr=%h want op=1 addr=0", pg_optype, pg_req_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    pg_ack = 1'b1;
    @(negedge clk);
    pg_ack = 1'b0;
    n_checks++;
    if (req_ack !== 2'b01 || pg_req !== 1'b0 || req_err !== 1'b0 || grant !== 2'b01)
      $display("FAIL single_ack: got ack=%b pg_req=%b err=%b grant=%b want 01 0 0 01",
               req_ack, pg_req, req_err, grant);
    else n_pass++;
    req = 2'b00;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 2'b00 || grant !== 2'b00 || busy !== 1'b0)
      $display("FAIL single_idle: got ack=%b grant=%b busy=%b want 00 00 0",
               req_ack, grant, busy);
    else n_pass++;
    pg_ack = 1'b1;
    @(negedge clk);
    pg_ack = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || req_ack !== 2'b00)
      $display("FAIL idle_ack_ignored: got busy=%b ack=%b want 0 00", busy, req_ack);
    else n_pass++;
  endtask

  task automatic test_addr_hold();
    req              = 2'b10;
    req_optype       = 2'b00;
    req_addr[55:28]  = 28'h0000100;
    @(negedge clk);
    n_checks++;
    if (pg_req !== 1'b1 || grant !== 2'b10 || pg_req_addr !== 28'h0000100 || pg_optype !== 1'b0)
      $display("FAIL hold_issue: got pg_req=%b grant=%b addr=%h op=%b want 1 10 0000100 0",
               pg_req, grant, pg_req_addr, pg_optype);
    else n_pass++;
    req_addr[55:28] = 28'h0000200;
    req_optype      = 2'b10;
    req             = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pg_req_addr !== 28'h0000100 || pg_optype !== 1'b0)
      $display("FAIL hold_stable: got addr=%h op=%b want 0000100 0", pg_req_addr, pg_optype);
    else n_pass++;
    n_checks++;
    if (pg_req !== 1'b1 || grant !== 2'b10)
      $display("FAIL hold_no_abort: got pg_req=%b grant=%b want 1 10", pg_req, grant);
    else n_pass++;
    pg_ack = 1'b1;
    @(negedge clk);
    pg_ack = 1'b0;
    n_checks++;
    if (req_ack !== 2'b10 || pg_req_addr !== 28'h0000100)
      $display("FAIL hold_ack: got ack=%b addr=%h want 10 0000100", req_ack, pg_req_addr);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic all_high;
    req            = 2'b01;
    req_optype     = 2'b00;
    req_addr[27:0] = 28'h0ABCDEF;
    all_high       = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (pg_req !== 1'b1) all_high = 1'b0;
    end
    n_checks++;
    if (all_high !== 1'b1)
      $display("FAIL to_held16: got early drop=%b want pg_req high 16 cycles", ~all_high);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pg_req !== 1'b0 || req_ack !== 2'b01 || req_err !== 1'b1 || timeout_err !== 1'b1)
      $display("FAIL to_fire: got pg_req=%b ack=%b err=%b terr=%b want 0 01 1 1",
               pg_req, req_ack, req_err, timeout_err);
    else n_pass++;
    req = 2'b00;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 2'b00 || req_err !== 1'b0 || timeout_err !== 1'b1 || grant !== 2'b00)
      $display("FAIL to_after: got ack=%b err=%b terr=%b grant=%b want 00 0 1 00",
               req_ack, req_err, timeout_err, grant);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b1)
      $display("FAIL to_sticky: got terr=%b want 1", timeout_err);
    else n_pass++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0)
      $display("FAIL to_clear: got terr=%b want 0", timeout_err);
    else n_pass++;
  endtask

  task automatic test_ack_at_limit();
    logic all_high;
    req      = 2'b10;
    all_high = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (pg_req !== 1'b1) all_high = 1'b0;
    end
    pg_ack = 1'b1;
    @(negedge clk);
    pg_ack = 1'b0;
    n_checks++;
    if (all_high !== 1'b1)
      $display("FAIL limit_held: got early drop=%b want pg_req high 16 cycles", ~all_high);
    else n_pass++;
    n_checks++;
    if (req_ack !== 2'b10 || req_err !== 1'b0 || timeout_err !== 1'b0 || pg_req !== 1'b0)
      $display("FAIL limit_ack: got ack=%b err=%b terr=%b pg_req=%b want 10 0 0 0",
               req_ack, req_err, timeout_err, pg_req);
    else n_pass++;
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    logic       seen;
    rst_n = 1'b0;
    req   = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp  = (t % 2 == 0) ? 2'b01 : 2'b10;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (l_pg_req === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b1) $display("FAIL b2b_wait%0d: got no pg_req want pg_req within 10", t);
      else n_pass++;
      n_checks++;
      if (l_grant !== exp) $display("FAIL b2b_grant%0d: got %b want %b", t, l_grant, exp);
      else n_pass++;
      repeat (49) @(negedge clk);
      l_pg_ack = 1'b1;
      @(negedge clk);
      l_pg_ack = 1'b0;
      n_checks++;
      if (l_req_ack !== exp || l_req_err !== 1'b0)
        $display("FAIL b2b_ack%0d: got ack=%b err=%b want %b 0", t, l_req_ack, l_req_err, exp);
      else n_pass++;
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_issue();
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    rst_n    = 1'b1;
    req_addr = {28'h0000123, 28'h0000456};
    req      = 2'b10;
    @(negedge clk);
    n_checks++;
    if (pg_req !== 1'b1 || grant !== 2'b10 || pg_req_addr !== 28'h0000123)
      $display("FAIL rst_pre: got pg_req=%b grant=%b addr=%h want 1 10 0000123",
               pg_req, grant, pg_req_addr);
    else n_pass++;
    req = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pg_req, grant, req_ack, req_err, busy, timeout_err} !== 8'h00)
      $display("FAIL rst_async: got %b want 00000000",
               {pg_req, grant, req_ack, req_err, busy, timeout_err});
    else n_pass++;
    n_checks++;
    if (pg_optype !== 1'b0 || pg_req_addr !== 28'h0)
      $display("FAIL rst_async_data: got op=%b addr=%h want 0 0", pg_optype, pg_req_addr);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ack !== 2'b00 || pg_req !== 1'b0)
      $display("FAIL rst_hold: got ack=%b pg_req=%b want 00 0", req_ack, pg_req);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b01 || pg_req !== 1'b1 || pg_req_addr !== 28'h0000456)
      $display("FAIL rst_first: got grant=%b pg_req=%b addr=%h want 01 1 0000456",
               grant, pg_req, pg_req_addr);
    else n_pass++;
    req = 2'b00;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single();
    test_addr_hold();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_reset_in_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
